// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction-fetch path: widths, opcode field,
// opcode constants and the fetch state encoding.
package isa_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 13;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpLoad = 3'b010,
    OpHalt = 3'b111
  } opcode_e;

  typedef enum logic {
    StFetch,
    StHalted
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [2:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller, instruction memory, redirect source
// and the decode stage.
interface fetch_controller_if
  import isa_pkg::*;
();

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry shifting FIFO of {pc, instr}; slot0 is always the head, so the head
// output holds its last value once the queue drains.
module fetch_queue
  import isa_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = push_entry_i;
          end else begin
            slot0_d = push_entry_i;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = push_entry_i;
          end else begin
            slot1_d = push_entry_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
          end
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = slot0_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory address,
// buffers fetched words for decode and handles redirects and HALT.
module fetch_controller
  import isa_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [2:0]        HALT_OP  = OpHalt
) (
  input  logic                      clk,
  input  logic                      reset,
  fetch_controller_if.master        bus,
  output logic                      halted
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_state_e      state_q, state_d;

  logic         q_push, q_pop, q_full, q_empty;
  logic [1:0]   q_count;
  fetch_entry_t q_head, q_push_entry;
  logic         is_halt;

  // Redirect suppresses pop so a head presented in that cycle is dropped, not consumed.
  assign q_pop        = !q_empty && bus.out_ready && !bus.redirect_valid;
  assign q_push       = (state_q == StFetch) && !bus.redirect_valid && (!q_full || q_pop);
  assign q_push_entry = '{pc: pc_q, instr: bus.imem_instr};
  assign is_halt      = (get_opcode(bus.imem_instr) == HALT_OP);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = StFetch;
    end else if (q_push) begin
      if (is_halt) begin
        state_d = StHalted;
      end else begin
        pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= StFetch;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_queue u_fetch_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (q_push),
    .pop_i        (q_pop),
    .flush_i      (bus.redirect_valid),
    .push_entry_i (q_push_entry),
    .count_o      (q_count),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_o       (q_head)
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = !q_empty;
  assign bus.out_instr = q_head.instr;
  assign bus.out_pc    = q_head.pc;
  assign halted        = (state_q == StHalted);

  logic unused_count;
  assign unused_count = ^q_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: memory model, hand-computed expectations.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halted;
  logic [15:0] mem [16];
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_controller_if bus ();

  fetch_controller dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.master),
    .halted (halted)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = mem[bus.imem_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [3:0] pc, input logic [15:0] instr);
    check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_eq({tag, "_pc"}, {28'd0, bus.out_pc}, {28'd0, pc});
    check_eq({tag, "_instr"}, {16'd0, bus.out_instr}, {16'd0, instr});
  endtask

  task automatic redirect_to(input logic [3:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
    mem[0]  = 16'h0050;
    mem[1]  = 16'h2C20;
    mem[2]  = 16'h4400;
    mem[15] = 16'h0050;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset values
    #2;
    check_eq("rst_addr", {28'd0, bus.imem_addr}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_instr", {16'd0, bus.out_instr}, 32'd0);
    check_eq("rst_pc", {28'd0, bus.out_pc}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);

    // Streaming ADD, SUB, LOAD
    do_reset();
    check_eq("t1_valid0", {31'd0, bus.out_valid}, 32'd0);
    tick();
    expect_head("t1_h0", 4'd0, 16'h0050);
    tick();
    expect_head("t1_h1", 4'd1, 16'h2C20);
    tick();
    expect_head("t1_h2", 4'd2, 16'h4400);

    // Backpressure: two buffered, fetch stalls at 2
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    expect_head("t2_hold", 4'd0, 16'h0050);
    check_eq("t2_addr", {28'd0, bus.imem_addr}, 32'd2);
    bus.out_ready = 1'b1;
    expect_head("t2_d0", 4'd0, 16'h0050);
    tick();
    expect_head("t2_d1", 4'd1, 16'h2C20);
    tick();
    expect_head("t2_d2", 4'd2, 16'h4400);
    tick();
    expect_head("t2_d3", 4'd3, 16'h0103);

    // PC wrap 14, 15, 0, 1
    do_reset();
    redirect_to(4'd14);
    check_eq("t3_addr", {28'd0, bus.imem_addr}, 32'd14);
    check_eq("t3_valid0", {31'd0, bus.out_valid}, 32'd0);
    tick();
    expect_head("t3_w14", 4'd14, 16'h010E);
    tick();
    expect_head("t3_w15", 4'd15, 16'h0050);
    tick();
    expect_head("t3_w0", 4'd0, 16'h0050);
    tick();
    expect_head("t3_w1", 4'd1, 16'h2C20);

    // HALT at address 3
    mem[3] = 16'hE003;
    do_reset();
    tick();
    tick();
    tick();
    check_eq("t4_halt_pre", {31'd0, halted}, 32'd0);
    tick();
    expect_head("t4_hw", 4'd3, 16'hE003);
    check_eq("t4_halted", {31'd0, halted}, 32'd1);
    check_eq("t4_addr", {28'd0, bus.imem_addr}, 32'd3);
    tick();
    tick();
    check_eq("t4_drained", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t4_addr_hold", {28'd0, bus.imem_addr}, 32'd3);
    check_eq("t4_still_halted", {31'd0, halted}, 32'd1);
    redirect_to(4'd0);
    check_eq("t4_unhalt", {31'd0, halted}, 32'd0);
    check_eq("t4_raddr", {28'd0, bus.imem_addr}, 32'd0);
    tick();
    expect_head("t4_restart", 4'd0, 16'h0050);
    mem[3] = 16'h0103;

    // Full queue + redirect with out_ready=1 drops pc4/pc5
    do_reset();
    redirect_to(4'd4);
    bus.out_ready = 1'b0;
    tick();
    tick();
    tick();
    expect_head("t5_full", 4'd4, 16'h0104);
    check_eq("t5_addr", {28'd0, bus.imem_addr}, 32'd6);
    bus.out_ready = 1'b1;
    redirect_to(4'd9);
    check_eq("t5_flush", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t5_raddr", {28'd0, bus.imem_addr}, 32'd9);
    tick();
    expect_head("t5_next", 4'd9, 16'h0109);

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    tick();
    tick();
    expect_head("t6_pre", 4'd9, 16'h0109);
    #1 reset = 1'b1;
    #1;
    check_eq("t6_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t6_addr", {28'd0, bus.imem_addr}, 32'd0);
    check_eq("t6_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
